// File: rtl/or_dut_initiator.sv
// ---------------------------------------------------------------------------
// or_dut_initiator
//
// Bus master for the OR-combining delayed DUT. Takes one (a, b) command at a
// time, polls the DUT status registers for space, pushes A and B, polls until
// a result is queued, then reads (and thereby dequeues) Y and presents it on a
// valid/ready response port. A poll that keeps failing for POLL_LIMIT+1
// consecutive cycles aborts the command with rsp_err=1.
//
// Parameters
//   POLL_W      width of the poll timeout counter
//   POLL_LIMIT  max consecutive failing polls in one poll state (< 2**POLL_W)
//
// Ports
//   CLK, RST_N                     clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_a/b    command input (ready only while idle)
//   rsp_valid/rsp_ready            response handshake
//   rsp_data/rsp_err               Y value read from the DUT / timeout flag
//   write_address/data/en, rdy     DUT write port
//   read_address/en, data, rdy     DUT read port (read_data combinational)
//   txn_count                      successful responses accepted (wraps)
// ---------------------------------------------------------------------------
module or_dut_initiator #(
  parameter int unsigned POLL_W     = 10,
  parameter int unsigned POLL_LIMIT = 1023
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_a,
  input  logic        cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_data,
  output logic        rsp_err,
  output logic [2:0]  write_address,
  output logic        write_data,
  output logic        write_en,
  input  logic        write_rdy,
  output logic [2:0]  read_address,
  output logic        read_en,
  input  logic        read_data,
  input  logic        read_rdy,
  output logic [15:0] txn_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POLL_A = 3'd1;
  localparam logic [2:0] S_WR_A   = 3'd2;
  localparam logic [2:0] S_POLL_B = 3'd3;
  localparam logic [2:0] S_WR_B   = 3'd4;
  localparam logic [2:0] S_POLL_Y = 3'd5;
  localparam logic [2:0] S_RD_Y   = 3'd6;
  localparam logic [2:0] S_RESP   = 3'd7;

  // DUT register map
  localparam logic [2:0] A_STAT_A = 3'd0;  // A-FIFO not full
  localparam logic [2:0] A_STAT_B = 3'd1;  // B-FIFO not full
  localparam logic [2:0] A_STAT_Y = 3'd2;  // Y-FIFO not empty
  localparam logic [2:0] A_DATA_Y = 3'd3;  // Y data, dequeued by the read
  localparam logic [2:0] A_PUSH_A = 3'd4;
  localparam logic [2:0] A_PUSH_B = 3'd5;

  localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_LIMIT);

  logic [2:0]        state_q,     state_d;
  logic [POLL_W-1:0] poll_cnt_q,  poll_cnt_d;
  logic              a_q,         a_d;
  logic              b_q,         b_d;
  logic              rsp_data_q,  rsp_data_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [15:0]       txn_count_q, txn_count_d;

  logic poll_ok;
  assign poll_ok = read_rdy && read_data;

  // NOTE: every signal written here is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    poll_cnt_d  = poll_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    txn_count_d = txn_count_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d     = cmd_a;
          b_d     = cmd_b;
          state_d = S_POLL_A;
        end
      end
      S_POLL_A, S_POLL_B, S_POLL_Y: begin
        if (poll_ok) begin
          case (state_q)
            S_POLL_A: state_d = S_WR_A;
            S_POLL_B: state_d = S_WR_B;
            default:  state_d = S_RD_Y;
          endcase
        end else if (poll_cnt_q == POLL_MAX) begin
          // Abort; A/B may already sit in the DUT, the sequencer cleans up.
          state_d    = S_RESP;
          rsp_err_d  = 1'b1;
          rsp_data_d = 1'b0;
        end else begin
          poll_cnt_d = poll_cnt_q + POLL_W'(1);
        end
      end
      S_WR_A: if (write_rdy) state_d = S_POLL_B;
      S_WR_B: if (write_rdy) state_d = S_POLL_Y;
      S_RD_Y: begin
        if (read_rdy) begin
          rsp_data_d = read_data;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          if (!rsp_err_q) txn_count_d = txn_count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Each poll state gets a fresh timeout budget.
    if (state_d != state_q) poll_cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      poll_cnt_q  <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      rsp_data_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      poll_cnt_q  <= poll_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      txn_count_q <= txn_count_d;
    end
  end

  // Bus strobes depend on the state register only, so they are glitch-free
  // and never combinationally loop back through the DUT's ready/data paths.
  always_comb begin
    write_en      = 1'b0;
    write_address = 3'd0;
    write_data    = 1'b0;
    read_en       = 1'b0;
    read_address  = 3'd0;
    case (state_q)
      S_POLL_A: begin read_en = 1'b1; read_address = A_STAT_A; end
      S_POLL_B: begin read_en = 1'b1; read_address = A_STAT_B; end
      S_POLL_Y: begin read_en = 1'b1; read_address = A_STAT_Y; end
      S_RD_Y:   begin read_en = 1'b1; read_address = A_DATA_Y; end
      S_WR_A:   begin write_en = 1'b1; write_address = A_PUSH_A; write_data = a_q; end
      S_WR_B:   begin write_en = 1'b1; write_address = A_PUSH_B; write_data = b_q; end
      default:  ;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_or_dut_initiator.sv
// ---------------------------------------------------------------------------
// tb_or_dut_initiator
//
// Drives or_dut_initiator against a behavioural DUT responder that can act as
// an ideal target (all status 1, Y = last A | last B) or as a delayed FIFO
// DUT (depth-2 A/B FIFOs, Y appears a few cycles after both operands, rdy
// lines periodically low). Expected responses go to a scoreboard queue when a
// command is issued and are compared when the response handshake happens.
// ---------------------------------------------------------------------------
module tb_or_dut_initiator;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        cmd_valid, cmd_ready, cmd_a, cmd_b;
  logic        rsp_valid, rsp_ready, rsp_data, rsp_err;
  logic [2:0]  write_address, read_address;
  logic        write_data, write_en, write_rdy;
  logic        read_en, read_data, read_rdy;
  logic [15:0] txn_count;

  always #5 CLK = ~CLK;

  or_dut_initiator #(.POLL_W(10), .POLL_LIMIT(7)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .write_address(write_address), .write_data(write_data), .write_en(write_en),
    .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
    .read_data(read_data), .read_rdy(read_rdy), .txn_count(txn_count)
  );

  typedef struct packed { logic rd; logic wr; logic [2:0] addr; logic data; } bus_ev_t;
  typedef struct packed { logic data; logic err; } rsp_t;

  bus_ev_t bus_log[$];
  rsp_t    exp_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_txn = 16'd0;

  // ---------------- responder model ----------------
  logic        ideal_mode = 1'b1;
  logic        y_stuck = 1'b0;
  int unsigned wr_block_req = 0;
  int unsigned wr_block_used = 0;
  int unsigned cyc = 0;
  int unsigned pushes_a = 0;

  bit          a_fifo[$], b_fifo[$], y_fifo[$], y_pipe_v[$];
  int unsigned y_pipe_t[$];
  logic        st_a = 1'b1, st_b = 1'b1, st_y = 1'b0, y_head = 1'b0;
  logic        last_a = 1'b0, last_b = 1'b0;

  always_comb begin
    read_data = 1'b0;
    case (read_address)
      3'd0: read_data = ideal_mode ? 1'b1 : st_a;
      3'd1: read_data = ideal_mode ? 1'b1 : st_b;
      3'd2: read_data = y_stuck ? 1'b0 : (ideal_mode ? 1'b1 : st_y);
      3'd3: read_data = ideal_mode ? (last_a | last_b) : y_head;
      default: read_data = 1'b0;
    endcase
  end

  // Bus transfers happen on the rising edge; visible status via <= so the
  // DUT samples pre-edge values.
  initial forever begin
    @(posedge CLK);
    cyc++;
    if (write_en && write_rdy) begin
      if (write_address == 3'd4) begin
        pushes_a++;
        last_a <= write_data;
        if (!ideal_mode) a_fifo.push_back(write_data);
      end else if (write_address == 3'd5) begin
        last_b <= write_data;
        if (!ideal_mode) b_fifo.push_back(write_data);
      end
    end
    if (read_en && read_rdy && read_address == 3'd3 && y_fifo.size() > 0)
      void'(y_fifo.pop_front());
    while (y_pipe_t.size() > 0 && y_pipe_t[0] <= cyc) begin
      y_fifo.push_back(y_pipe_v.pop_front());
      void'(y_pipe_t.pop_front());
    end
    if (a_fifo.size() > 0 && b_fifo.size() > 0) begin
      y_pipe_v.push_back(a_fifo.pop_front() | b_fifo.pop_front());
      y_pipe_t.push_back(cyc + 3);
    end
    st_a   <= (a_fifo.size() < 2);
    st_b   <= (b_fifo.size() < 2);
    st_y   <= (y_fifo.size() > 0);
    y_head <= (y_fifo.size() > 0) ? y_fifo[0] : 1'b0;
  end

  // Ready lines change on the falling edge.
  initial begin
    write_rdy = 1'b1;
    read_rdy  = 1'b1;
    forever begin
      @(negedge CLK);
      if (ideal_mode) begin
        write_rdy = 1'b1;
        read_rdy  = 1'b1;
      end else begin
        read_rdy  = (cyc % 3) != 0;
        write_rdy = (cyc % 4) != 1;
      end
      if (wr_block_used < wr_block_req && write_en && write_address == 3'd4) begin
        write_rdy = 1'b0;
        wr_block_used++;
      end
    end
  end

  // Bus monitor
  initial forever begin
    @(negedge CLK);
    if (read_en || write_en)
      bus_log.push_back({read_en, write_en, (read_address | write_address), write_data});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 400000", $time);
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic send_cmd(input logic a, input logic b);
    int k = 0;
    @(negedge CLK);
    while (cmd_ready !== 1'b1 && k < 50) begin @(negedge CLK); k++; end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL cmd_accept: cmd_ready=%b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
  endtask

  // Waits for the response, compares it to the scoreboard head, holds
  // rsp_ready low for 'hold' cycles checking stability, then accepts it.
  task automatic wait_rsp(input int budget, input int hold, input string name, output int lat);
    int   k = 0;
    logic ready_seen = 1'b0;
    rsp_t exp;
    do begin
      @(negedge CLK);
      k++;
      if (rsp_valid !== 1'b1 && cmd_ready === 1'b1) ready_seen = 1'b1;
    end while (rsp_valid !== 1'b1 && k < budget);
    lat = k - 1;
    n_cmp++;
    if (ready_seen) begin
      n_bad++;
      $display("FAIL %s_busy: cmd_ready was 1 during transaction, expected 0", name);
    end
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_timeout: no rsp_valid within %0d cycles", name, budget);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s_sb: response %b%b with empty scoreboard", name, rsp_data, rsp_err);
      return;
    end
    exp = exp_q.pop_front();
    if ({rsp_data, rsp_err} !== {exp.data, exp.err}) begin
      n_bad++;
      $display("FAIL %s_rsp: data/err=%b/%b expected %b/%b", name, rsp_data, rsp_err, exp.data, exp.err);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, exp.data, exp.err}) begin
        n_bad++;
        $display("FAIL %s_hold%0d: valid/data/err=%b/%b/%b expected 1/%b/%b",
                 name, i, rsp_valid, rsp_data, rsp_err, exp.data, exp.err);
      end
    end
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1 rsp_ready = 1'b0;
    if (!exp.err) exp_txn = exp_txn + 16'd1;
    @(negedge CLK);
    n_cmp++;
    if ({cmd_ready, rsp_valid, txn_count} !== {1'b1, 1'b0, exp_txn}) begin
      n_bad++;
      $display("FAIL %s_after: ready/valid/txn=%b/%b/%h expected 1/0/%h",
               name, cmd_ready, rsp_valid, txn_count, exp_txn);
    end
  endtask

  function automatic int count_ev(input int from, input bus_ev_t ev);
    int n = 0;
    for (int i = from; i < bus_log.size(); i++) if (bus_log[i] == ev) n++;
    return n;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_err, write_en, read_en, write_data} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_ctrl: rdy/val/dat/err/we/re/wd=%b%b%b%b%b%b%b expected 1000000",
               cmd_ready, rsp_valid, rsp_data, rsp_err, write_en, read_en, write_data);
    end
    n_cmp++;
    if ({write_address, read_address} !== 6'd0) begin
      n_bad++;
      $display("FAIL reset_addr: wa/ra=%0d/%0d expected 0/0", write_address, read_address);
    end
    n_cmp++;
    if (txn_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_txn: txn_count=%h expected 0000", txn_count);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_ideal();
    bus_ev_t exp_seq [6];
    int      start, lat;
    exp_seq[0] = {1'b1, 1'b0, 3'd0, 1'b0};
    exp_seq[1] = {1'b0, 1'b1, 3'd4, 1'b1};
    exp_seq[2] = {1'b1, 1'b0, 3'd1, 1'b0};
    exp_seq[3] = {1'b0, 1'b1, 3'd5, 1'b0};
    exp_seq[4] = {1'b1, 1'b0, 3'd2, 1'b0};
    exp_seq[5] = {1'b1, 1'b0, 3'd3, 1'b0};
    ideal_mode = 1'b1;
    start = bus_log.size();
    send_cmd(1'b1, 1'b0);
    exp_q.push_back('{data: 1'b1, err: 1'b0});
    wait_rsp(20, 0, "ideal", lat);
    n_cmp++;
    if (lat != 6) begin
      n_bad++;
      $display("FAIL ideal_latency: rsp_valid after edge T+%0d expected T+6", lat);
    end
    n_cmp++;
    if (bus_log.size() - start != 6) begin
      n_bad++;
      $display("FAIL ideal_bus_len: %0d strobes expected 6", bus_log.size() - start);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (bus_log[start + i] !== exp_seq[i]) begin
          n_bad++;
          $display("FAIL ideal_bus%0d: rd/wr/addr/d=%b expected %b", i, bus_log[start + i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_real();
    int start, lat;
    ideal_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic a, b;
      a = i[1];
      b = i[0];
      start = bus_log.size();
      send_cmd(a, b);
      exp_q.push_back('{data: a | b, err: 1'b0});
      wait_rsp(300, 0, "real", lat);
      n_cmp++;
      if (count_ev(start, {1'b1, 1'b0, 3'd3, 1'b0}) != 1) begin
        n_bad++;
        $display("FAIL real_rd3_%0d: %0d Y reads expected 1", i, count_ev(start, {1'b1, 1'b0, 3'd3, 1'b0}));
      end
    end
    ideal_mode = 1'b1;
  endtask

  task automatic test_timeout();
    int start, lat;
    ideal_mode = 1'b1;
    y_stuck = 1'b1;
    start = bus_log.size();
    send_cmd(1'b1, 1'b1);
    exp_q.push_back('{data: 1'b0, err: 1'b1});
    wait_rsp(100, 0, "timeout", lat);
    n_cmp++;
    if (count_ev(start, {1'b1, 1'b0, 3'd2, 1'b0}) != 8) begin
      n_bad++;
      $display("FAIL timeout_polls: %0d Y-status reads expected 8", count_ev(start, {1'b1, 1'b0, 3'd2, 1'b0}));
    end
    n_cmp++;
    if (count_ev(start, {1'b1, 1'b0, 3'd3, 1'b0}) != 0) begin
      n_bad++;
      $display("FAIL timeout_rd3: %0d Y reads expected 0", count_ev(start, {1'b1, 1'b0, 3'd3, 1'b0}));
    end
    y_stuck = 1'b0;
  endtask

  task automatic test_stall();
    int          start, lat;
    int unsigned a0;
    ideal_mode = 1'b1;
    wr_block_req = wr_block_req + 5;
    start = bus_log.size();
    a0 = pushes_a;
    send_cmd(1'b1, 1'b0);
    exp_q.push_back('{data: 1'b1, err: 1'b0});
    wait_rsp(50, 4, "stall", lat);
    n_cmp++;
    if (count_ev(start, {1'b0, 1'b1, 3'd4, 1'b1}) != 6) begin
      n_bad++;
      $display("FAIL stall_wr4: %0d strobes at addr 4 with d=1, expected 6", count_ev(start, {1'b0, 1'b1, 3'd4, 1'b1}));
    end
    n_cmp++;
    if (pushes_a - a0 != 1) begin
      n_bad++;
      $display("FAIL stall_push: %0d A pushes expected 1", pushes_a - a0);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int lat;
    ideal_mode = 1'b1;
    y_stuck = 1'b1;
    send_cmd(1'b0, 1'b1);
    @(negedge CLK);
    while (!(read_en === 1'b1 && read_address === 3'd2) && k < 20) begin @(negedge CLK); k++; end
    n_cmp++;
    if (!(read_en === 1'b1 && read_address === 3'd2)) begin
      n_bad++;
      $display("FAIL rstmid_reach: read_en/addr=%b/%0d expected 1/2", read_en, read_address);
    end
    RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    exp_txn = 16'd0;
    n_cmp++;
    if ({read_en, write_en, cmd_ready, rsp_valid, txn_count} !== {4'b0010, 16'd0}) begin
      n_bad++;
      $display("FAIL rstmid_state: re/we/rdy/val/txn=%b%b%b%b/%h expected 0010/0000",
               read_en, write_en, cmd_ready, rsp_valid, txn_count);
    end
    y_stuck = 1'b0;
    send_cmd(1'b1, 1'b1);
    exp_q.push_back('{data: 1'b1, err: 1'b0});
    wait_rsp(50, 0, "rstmid", lat);
  endtask

  task automatic test_wrap();
    int lat;
    @(negedge CLK);
    force dut.txn_count_q = 16'hFFFF;
    @(posedge CLK);
    @(negedge CLK);
    release dut.txn_count_q;
    @(negedge CLK);
    exp_txn = 16'hFFFF;
    n_cmp++;
    if (txn_count !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_preset: txn_count=%h expected ffff", txn_count);
    end
    send_cmd(1'b0, 1'b0);
    exp_q.push_back('{data: 1'b0, err: 1'b0});
    wait_rsp(20, 0, "wrap", lat);
    n_cmp++;
    if (txn_count !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_zero: txn_count=%h expected 0000", txn_count);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    cmd_valid = 1'b0;
    cmd_a = 1'b0;
    cmd_b = 1'b0;
    rsp_ready = 1'b0;
    test_reset();
    test_ideal();
    test_real();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_wrap();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d responses outstanding expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
